// File: rtl/inst_buffer.sv
// Fetch-side instruction buffer: owns the fetch PC, accepts in-order icache lanes
// into a circular buffer and presents the oldest N_WAY entries to dispatch.
module inst_buffer #(
   parameter int XLEN = 32,
   parameter int N_WAY = 3,
   parameter int IB_SIZE = 8,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [XLEN-1:0]              redirect_pc,
   input  logic [N_WAY*XLEN-1:0]        Icache_data_out,
   input  logic [N_WAY*XLEN-1:0]        Icache_addr_out,
   input  logic [N_WAY-1:0]             Icache_valid_out,
   output logic [XLEN-1:0]              proc2Icache_addr,
   output logic [$clog2(N_WAY):0]       proc2Icache_count,
   input  logic [$clog2(N_WAY):0]       dispatch_count,
   output logic [N_WAY*XLEN-1:0]        ib_inst,
   output logic [N_WAY*XLEN-1:0]        ib_pc,
   output logic [N_WAY-1:0]             ib_valid
);

   localparam int PTRW = $clog2(IB_SIZE);
   localparam int CNTW = PTRW + 1;
   localparam int LCW  = $clog2(N_WAY) + 1;

   logic [XLEN-1:0] pcMem_q   [IB_SIZE];
   logic [XLEN-1:0] instMem_q [IB_SIZE];

   logic [PTRW-1:0] head_q, head_d;
   logic [PTRW-1:0] tail_q, tail_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [XLEN-1:0] fetchPc_q, fetchPc_d;

   logic [N_WAY-1:0] laneOk;
   logic [CNTW-1:0]  dispReq;
   logic [CNTW-1:0]  dispN;
   logic [CNTW-1:0]  space;
   logic [CNTW-1:0]  acceptN;
   logic [CNTW-1:0]  freeSlots;
   logic             run;

   // A lane is usable only if it is valid and carries the PC we expect at that
   // position, so stale or repeated icache responses are naturally discarded.
   always_comb begin
      laneOk = '0;
      for (int i = 0; i < N_WAY; i++) begin
         laneOk[i] = Icache_valid_out[i] &&
                     (Icache_addr_out[i*XLEN +: XLEN] == fetchPc_q + XLEN'(4 * i));
      end
   end

   // Space freed by this cycle's dispatch may be refilled in the same cycle.
   always_comb begin
      dispReq = CNTW'(dispatch_count);
      dispN   = (dispReq > count_q) ? count_q : dispReq;
      space   = CNTW'(IB_SIZE) - count_q + dispN;
      acceptN = '0;
      run     = 1'b1;
      for (int i = 0; i < N_WAY; i++) begin
         if (run && laneOk[i] && (CNTW'(i) < space)) begin
            acceptN = acceptN + CNTW'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      fetchPc_d = fetchPc_q;
      if (flush) begin
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         fetchPc_d = redirect_pc;
      end else begin
         head_d    = head_q + dispN[PTRW-1:0];
         tail_d    = tail_q + acceptN[PTRW-1:0];
         count_d   = count_q + acceptN - dispN;
         fetchPc_d = fetchPc_q + (XLEN'(acceptN) << 2);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         fetchPc_q <= RESET_PC;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         fetchPc_q <= fetchPc_d;
      end
   end

   // Entry storage needs no reset; validity is tracked by count alone.
   always_ff @(posedge clock) begin
      if (!flush) begin
         for (int i = 0; i < N_WAY; i++) begin
            if (CNTW'(i) < acceptN) begin
               pcMem_q[tail_q + PTRW'(i)]   <= Icache_addr_out[i*XLEN +: XLEN];
               instMem_q[tail_q + PTRW'(i)] <= Icache_data_out[i*XLEN +: XLEN];
            end
         end
      end
   end

   assign proc2Icache_addr = fetchPc_q;
   assign freeSlots        = CNTW'(IB_SIZE) - count_q;
   assign proc2Icache_count = (freeSlots >= CNTW'(N_WAY)) ? LCW'(N_WAY) : LCW'(freeSlots);

   always_comb begin
      ib_inst  = '0;
      ib_pc    = '0;
      ib_valid = '0;
      for (int i = 0; i < N_WAY; i++) begin
         ib_inst[i*XLEN +: XLEN] = instMem_q[head_q + PTRW'(i)];
         ib_pc[i*XLEN +: XLEN]   = pcMem_q[head_q + PTRW'(i)];
         ib_valid[i]             = (CNTW'(i) < count_q);
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboarded bench for inst_buffer: a queue-based reference model predicts the
// buffer contents and fetch PC; a monitor compares after every driven edge.
module tb_inst_buffer;

   localparam int NW  = 3;
   localparam int IBS = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [95:0] Icache_data_out = '0;
   logic [95:0] Icache_addr_out = '0;
   logic [2:0]  Icache_valid_out = '0;
   logic [2:0]  dispatch_count = '0;
   logic [31:0] proc2Icache_addr;
   logic [2:0]  proc2Icache_count;
   logic [95:0] ib_inst;
   logic [95:0] ib_pc;
   logic [2:0]  ib_valid;

   inst_buffer #(.XLEN(32), .N_WAY(NW), .IB_SIZE(IBS), .RESET_PC(32'h0)) dut (
      .clock(clock),
      .reset(reset),
      .flush(flush),
      .redirect_pc(redirect_pc),
      .Icache_data_out(Icache_data_out),
      .Icache_addr_out(Icache_addr_out),
      .Icache_valid_out(Icache_valid_out),
      .proc2Icache_addr(proc2Icache_addr),
      .proc2Icache_count(proc2Icache_count),
      .dispatch_count(dispatch_count),
      .ib_inst(ib_inst),
      .ib_pc(ib_pc),
      .ib_valid(ib_valid)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   typedef struct packed {
      logic [2:0]       valid;
      logic [2:0][31:0] pc;
      logic [2:0][31:0] inst;
      logic [31:0]      addr;
      logic [2:0]       req;
   } exp_t;

   entry_t      model[$];
   logic [31:0] mFetch = '0;
   exp_t        expQ[$];
   int          total = 0;
   int          bad = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected outputs derived from the model: the oldest three entries in order.
   function automatic exp_t snapshot();
      exp_t e;
      int   n;
      e = '0;
      n = model.size();
      e.addr = mFetch;
      e.req  = (IBS - n >= NW) ? 3'(NW) : 3'(IBS - n);
      for (int i = 0; i < NW; i++) begin
         if (i < n) begin
            e.valid[i] = 1'b1;
            e.pc[i]    = model[i].pc;
            e.inst[i]  = model[i].inst;
         end
      end
      return e;
   endfunction

   task automatic checkOutput(input exp_t e, input string tag);
      cmp({tag, ".valid"}, 32'(ib_valid), 32'(e.valid));
      cmp({tag, ".addr"}, proc2Icache_addr, e.addr);
      cmp({tag, ".req"}, 32'(proc2Icache_count), 32'(e.req));
      for (int i = 0; i < NW; i++) begin
         if (e.valid[i]) begin
            cmp($sformatf("%s.pc%0d", tag, i), ib_pc[i*32 +: 32], e.pc[i]);
            cmp($sformatf("%s.inst%0d", tag, i), ib_inst[i*32 +: 32], e.inst[i]);
         end
      end
   endtask

   // One clock of the reference model: retire, then append the accepted lanes.
   task automatic modelStep(input logic [2:0] v, input logic [31:0] a0, a1, a2,
                            input logic [31:0] d0, d1, d2, input int disp,
                            input logic fl, input logic [31:0] rpc);
      logic [31:0] a[3];
      logic [31:0] dt[3];
      int          n, d, space, k;
      a[0] = a0; a[1] = a1; a[2] = a2;
      dt[0] = d0; dt[1] = d1; dt[2] = d2;
      if (fl) begin
         model.delete();
         mFetch = rpc;
      end else begin
         n = model.size();
         d = (disp > n) ? n : disp;
         space = IBS - n + d;
         k = 0;
         for (int i = 0; i < NW; i++) begin
            if (k < space && v[i] && a[i] == mFetch + 32'(4 * i)) k++;
            else break;
         end
         repeat (d) void'(model.pop_front());
         for (int i = 0; i < k; i++) model.push_back('{pc: a[i], inst: dt[i]});
         mFetch = mFetch + 32'(4 * k);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] v, input logic [31:0] a0, a1, a2,
                                input int disp, input logic fl, input logic [31:0] rpc);
      logic [31:0] d0, d1, d2;
      d0 = $urandom; d1 = $urandom; d2 = $urandom;
      @(negedge clock);
      flush            = fl;
      redirect_pc      = rpc;
      Icache_valid_out = v;
      Icache_addr_out  = {a2, a1, a0};
      Icache_data_out  = {d2, d1, d0};
      dispatch_count   = 3'(disp);
      modelStep(v, a0, a1, a2, d0, d1, d2, disp, fl, rpc);
      expQ.push_back(snapshot());
   endtask

   task automatic idleInputs();
      flush = 1'b0;
      Icache_valid_out = '0;
      dispatch_count = '0;
   endtask

   // Monitor: every driven edge has exactly one queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e, "cyc");
         end
      end
   end

   initial begin
      exp_t        rstExp;
      logic [31:0] base, a0, a1, a2, rpc;
      logic [2:0]  v;
      int          r, disp;
      logic        fl;

      rstExp = '0;
      rstExp.addr = 32'h0;
      rstExp.req  = 3'd3;

      #1 reset = 1'b0;
      #1 checkOutput(rstExp, "reset");
      @(negedge clock);
      reset = 1'b1;

      applyStimulus(3'b111, 32'h0, 32'h4, 32'h8, 0, 1'b0, 0);
      applyStimulus(3'b101, 32'hC, 32'h10, 32'h14, 0, 1'b0, 0);
      applyStimulus(3'b111, 32'h20, 32'h24, 32'h28, 0, 1'b0, 0);
      applyStimulus(3'b111, 32'h10, 32'h14, 32'h18, 0, 1'b0, 0);
      applyStimulus(3'b111, 32'h1C, 32'h20, 32'h24, 0, 1'b0, 0);
      applyStimulus(3'b111, 32'h20, 32'h24, 32'h28, 2, 1'b0, 0);
      applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3, 1'b0, 0);
      applyStimulus(3'b111, 32'h28, 32'h2C, 32'h30, 1, 1'b1, 32'h100);
      applyStimulus(3'b111, 32'h18, 32'h1C, 32'h20, 0, 1'b0, 0);
      applyStimulus(3'b111, 32'h100, 32'h104, 32'h108, 0, 1'b0, 0);
      applyStimulus(3'b111, 32'h10C, 32'h110, 32'h114, 0, 1'b0, 0);
      applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3, 1'b0, 0);
      applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3, 1'b0, 0);
      applyStimulus(3'b111, 32'h118, 32'h11C, 32'h120, 0, 1'b0, 0);
      applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3, 1'b0, 0);
      applyStimulus(3'b000, 32'h0, 32'h0, 32'h0, 3, 1'b0, 0);

      for (int phase = 0; phase < 600; phase++) begin
         if (phase == 400) begin
            @(negedge clock);
            idleInputs();
            #2 reset = 1'b0;
            #1 checkOutput(rstExp, "midreset");
            model.delete();
            mFetch = 32'h0;
            @(negedge clock);
            reset = 1'b1;
         end
         r = $urandom_range(0, 99);
         if (r < 80) base = mFetch;
         else if (r < 90) base = mFetch + 32'(4 * $urandom_range(1, 3));
         else base = $urandom & 32'hFFFF_FFFC;
         a0 = base; a1 = base + 32'h4; a2 = base + 32'h8;
         if ($urandom_range(0, 9) == 0) a1 = a1 ^ 32'h40;
         if ($urandom_range(0, 9) == 0) a0 = a0 ^ 32'h80;
         v = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
         disp = (phase < 150) ? $urandom_range(0, 1) : $urandom_range(0, 3);
         fl = ($urandom_range(0, 29) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         applyStimulus(v, a0, a1, a2, disp, fl, rpc);
      end

      @(negedge clock);
      idleInputs();
      for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clock);
      #2;
      cmp("drain", 32'(expQ.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
